// File: rtl/vga_pkg.sv
// Shared VGA raster definitions: default 640x480@60 timing, stream-alignment
// states and the RGB888 pixel layout.
package vga_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;

    localparam int unsigned H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
    localparam int unsigned H_CNT_W = $clog2(H_TOTAL);
    localparam int unsigned V_CNT_W = $clog2(V_TOTAL);

    typedef enum logic [1:0] {
        ST_RESYNC,
        ST_ARMED,
        ST_RUN
    } tVgaState;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } tRgb888;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Free-running horizontal/vertical raster counters with active-area and
// sync-window decodes; order per axis is active, front porch, sync, back porch.
module vga_timing_counter
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    localparam int unsigned H_TOT   = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOT   = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned HW      = cnt_width(H_TOT),
    localparam int unsigned VW      = cnt_width(V_TOT)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    output logic [HW-1:0] o_h_cnt,
    output logic [VW-1:0] o_v_cnt,
    output logic          o_active,
    output logic          o_hsync_act,
    output logic          o_vsync_act
);

    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == HW'(H_TOT - 1)) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == VW'(V_TOT - 1)) ? '0 : r_v_cnt + VW'(1);
        end else begin
            r_h_cnt <= r_h_cnt + HW'(1);
        end
    end

    assign o_h_cnt     = r_h_cnt;
    assign o_v_cnt     = r_v_cnt;
    assign o_active    = (r_h_cnt < HW'(H_ACTIVE)) && (r_v_cnt < VW'(V_ACTIVE));
    assign o_hsync_act = (r_h_cnt >= HW'(H_ACTIVE + H_FP)) &&
                         (r_h_cnt <  HW'(H_ACTIVE + H_FP + H_SYNC));
    assign o_vsync_act = (r_v_cnt >= VW'(V_ACTIVE + V_FP)) &&
                         (r_v_cnt <  VW'(V_ACTIVE + V_FP + V_SYNC));

endmodule

// File: rtl/vga_out_driver.sv
// VGA output raster engine: aligns a valid/ready RGB888 stream with SOF to the
// raster and drives registered DAC pins plus sync pulses.
module vga_out_driver
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic        ul1Clock,
    input  logic        ul1Reset_n,
    input  logic [23:0] ul24PixelData,
    input  logic        ul1PixelSof,
    input  logic        ul1PixelValid,
    output logic        ul1PixelReady,
    output logic [7:0]  ul8Red,
    output logic [7:0]  ul8Green,
    output logic [7:0]  ul8Blue,
    output logic        ul1PixelClock,
    output logic        ul1Blank_n,
    output logic        ul1Sync_n,
    output logic        ul1HSync,
    output logic        ul1VSync,
    output logic        ul1FrameError
);

    localparam int unsigned HW = cnt_width(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int unsigned VW = cnt_width(V_ACTIVE + V_FP + V_SYNC + V_BP);

    logic [HW-1:0] w_h_cnt;
    logic [VW-1:0] w_v_cnt;
    logic          w_active;
    logic          w_hsync_act;
    logic          w_vsync_act;
    logic          w_origin;
    logic          w_sof_head;
    logic          w_ready;
    logic          w_show;
    logic          w_err;
    tVgaState      w_state_nxt;
    tRgb888        w_pix;

    tVgaState      r_state;
    logic          r_live;
    tRgb888        r_rgb;
    logic          r_blank_n;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_frame_err;

    vga_timing_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .i_clk       (ul1Clock),
        .i_rst_n     (ul1Reset_n),
        .o_h_cnt     (w_h_cnt),
        .o_v_cnt     (w_v_cnt),
        .o_active    (w_active),
        .o_hsync_act (w_hsync_act),
        .o_vsync_act (w_vsync_act)
    );

    assign w_origin   = (w_h_cnt == '0) && (w_v_cnt == '0);
    assign w_sof_head = ul1PixelValid && ul1PixelSof;
    assign w_pix      = ul24PixelData;

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_show      = 1'b0;
        w_err       = 1'b0;
        unique case (r_state)
            ST_RESYNC: begin
                w_ready = !w_sof_head;
                if (w_sof_head) w_state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
                if (w_origin) begin
                    w_ready = 1'b1;
                    w_show  = ul1PixelValid;
                    if (ul1PixelValid) w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // An SOF waiting in blanking is the next frame's head, not a misalignment.
                if (w_origin) begin
                    if (w_sof_head) begin
                        w_ready = 1'b1;
                        w_show  = 1'b1;
                    end else begin
                        w_err       = 1'b1;
                        w_state_nxt = ST_RESYNC;
                    end
                end else if (w_active) begin
                    if (!ul1PixelValid) begin
                        w_err       = 1'b1;
                        w_state_nxt = ST_RESYNC;
                    end else if (ul1PixelSof) begin
                        w_err       = 1'b1;
                        w_state_nxt = ST_ARMED;
                    end else begin
                        w_ready = 1'b1;
                        w_show  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_RESYNC;
        endcase
    end

    always_ff @(posedge ul1Clock) begin
        if (!ul1Reset_n) begin
            r_state     <= ST_RESYNC;
            r_live      <= 1'b0;
            r_rgb       <= '0;
            r_blank_n   <= 1'b0;
            r_hsync     <= ~SYNC_POL;
            r_vsync     <= ~SYNC_POL;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_live      <= 1'b1;
            r_rgb       <= (w_show && w_active) ? w_pix : '0;
            r_blank_n   <= w_active;
            r_hsync     <= w_hsync_act ? SYNC_POL : ~SYNC_POL;
            r_vsync     <= w_vsync_act ? SYNC_POL : ~SYNC_POL;
            r_frame_err <= w_err;
        end
    end

    // Ready stays low until the first cycle after reset release.
    assign ul1PixelReady = w_ready && r_live;
    assign ul8Red        = r_rgb.r;
    assign ul8Green      = r_rgb.g;
    assign ul8Blue       = r_rgb.b;
    assign ul1PixelClock = ~ul1Clock;
    assign ul1Blank_n    = r_blank_n;
    assign ul1Sync_n     = 1'b0;
    assign ul1HSync      = r_hsync;
    assign ul1VSync      = r_vsync;
    assign ul1FrameError = r_frame_err;

endmodule
